rc4_encrypt: RTL and testbench

RC4 encryptor for the lab 4 key-search system. Given a 24-bit secret key, it initialises and key-schedules an external 256-byte S RAM, generates the keystream and XORs it with a plaintext ROM. The result goes to a ciphertext RAM. Its purpose is to produce the encrypted-message images that the key-search datapath consumes, and to let the team generate them on chip and self-check decryption end to end.

---
 rtl/rc4_pkg.sv | 38 +++
 rtl/rc4_encrypt.sv | 155 +++++++++++++++
 tb/tb_rc4_encrypt.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared RC4 definitions used by the encryptor and the key-search datapath.
package rc4_pkg;

    localparam int S_DEPTH   = 256;
    localparam int KEY_BYTES = 3;

    typedef enum logic [4:0] {
        IDLE = 5'd0,
        INIT = 5'd1,
        K_RI = 5'd2,
        K_WI = 5'd3,
        K_RJ = 5'd4,
        K_WJ = 5'd5,
        K_SI = 5'd6,
        K_SJ = 5'd7,
        P_RI = 5'd8,
        P_WI = 5'd9,
        P_RJ = 5'd10,
        P_WJ = 5'd11,
        P_SI = 5'd12,
        P_SJ = 5'd13,
        P_WF = 5'd14,
        P_WC = 5'd15,
        DONE = 5'd16
    } rc4_enc_state_t;

    // Key byte (idx mod 3), byte 0 taken from the most significant end.
    function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [7:0] idx);
        logic [1:0] sel;
        sel = 2'(idx % 8'(KEY_BYTES));
        case (sel)
            2'd0:    key_byte = key[23:16];
            2'd1:    key_byte = key[15:8];
            default: key_byte = key[7:0];
        endcase
    endfunction

endpackage

// File: rtl/rc4_encrypt.sv
// RC4 encryptor: initialises and key-schedules an external S RAM, then XORs
// the keystream with a plaintext ROM into a ciphertext RAM.
module rc4_encrypt #(
    parameter int MSG_LEN   = 32,
    parameter int KEY_BYTES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] secret_key,
    output logic [7:0]  s_addr,
    output logic [7:0]  s_wdata,
    output logic        s_wren,
    input  logic [7:0]  s_rdata,
    output logic [7:0]  p_addr,
    input  logic [7:0]  p_rdata,
    output logic [7:0]  c_addr,
    output logic [7:0]  c_wdata,
    output logic        c_wren,
    output logic        busy,
    output logic        done_flag
);
    import rc4_pkg::*;

    localparam logic [7:0] LAST_IDX = 8'(S_DEPTH - 1);
    localparam logic [8:0] LAST_K   = 9'(MSG_LEN - 1);

    rc4_enc_state_t state;
    logic [7:0]     i, j, si, sj;
    logic [8:0]     k;
    logic [23:0]    key_q;
    logic [7:0]     j_ksa, j_prga;

    assign j_ksa  = j + s_rdata + key_byte(key_q, 8'(int'(i) % KEY_BYTES));
    assign j_prga = j + s_rdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            si    <= '0;
            sj    <= '0;
            key_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    key_q <= secret_key;
                    i     <= '0;
                    j     <= '0;
                    k     <= '0;
                    if (start) state <= INIT;
                end
                INIT: begin
                    i <= i + 8'd1;
                    if (i == LAST_IDX) begin
                        j     <= '0;
                        state <= K_RI;
                    end
                end
                K_RI: state <= K_WI;
                K_WI: state <= K_RJ;
                K_RJ: begin
                    si    <= s_rdata;
                    j     <= j_ksa;
                    state <= K_WJ;
                end
                K_WJ: state <= K_SI;
                K_SI: begin
                    sj    <= s_rdata;
                    state <= K_SJ;
                end
                K_SJ: begin
                    i <= i + 8'd1;
                    if (i == LAST_IDX) begin
                        j     <= '0;
                        state <= P_RI;
                    end else begin
                        state <= K_RI;
                    end
                end
                P_RI: begin
                    i     <= i + 8'd1;
                    state <= P_WI;
                end
                P_WI: state <= P_RJ;
                P_RJ: begin
                    si    <= s_rdata;
                    j     <= j_prga;
                    state <= P_WJ;
                end
                P_WJ: state <= P_SI;
                P_SI: begin
                    sj    <= s_rdata;
                    state <= P_SJ;
                end
                P_SJ: state <= P_WF;
                P_WF: state <= P_WC;
                P_WC: begin
                    k <= k + 9'd1;
                    if (k == LAST_K) state <= DONE;
                    else             state <= P_RI;
                end
                DONE: if (!start) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The single S port carries the swap write in P_SJ, so the keystream
    // address s[si+sj] is presented in P_WF and held through P_WC.
    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_wren  = 1'b0;
        c_wdata = '0;
        c_wren  = 1'b0;
        case (state)
            INIT: begin
                s_addr  = i;
                s_wdata = i;
                s_wren  = 1'b1;
            end
            K_RI, K_WI, P_WI: s_addr = i;
            P_RI:             s_addr = i + 8'd1;
            K_RJ:             s_addr = j_ksa;
            P_RJ:             s_addr = j_prga;
            K_WJ, P_WJ:       s_addr = j;
            K_SI, P_SI: begin
                s_addr  = i;
                s_wdata = s_rdata;
                s_wren  = 1'b1;
            end
            K_SJ, P_SJ: begin
                s_addr  = j;
                s_wdata = si;
                s_wren  = 1'b1;
            end
            P_WF: s_addr = si + sj;
            P_WC: begin
                s_addr  = si + sj;
                c_wdata = s_rdata ^ p_rdata;
                c_wren  = 1'b1;
            end
            default: ;
        endcase
    end

    assign p_addr    = k[7:0];
    assign c_addr    = k[7:0];
    assign busy      = (state != IDLE) && (state != DONE);
    assign done_flag = (state == DONE);

endmodule

// File: tb/tb_rc4_encrypt.sv
// Bench for rc4_encrypt: a 9-byte and a 256-byte instance, each with its own
// memories, checked against a behavioural RC4 model and literal vectors.
module tb_rc4_encrypt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        start_a, start_b;
    logic [23:0] key_a, key_b;
    logic [7:0]  s_addr_a, s_wdata_a, s_rdata_a, p_addr_a, p_rdata_a, c_addr_a, c_wdata_a;
    logic [7:0]  s_addr_b, s_wdata_b, s_rdata_b, p_addr_b, p_rdata_b, c_addr_b, c_wdata_b;
    logic        s_wren_a, c_wren_a, busy_a, done_a;
    logic        s_wren_b, c_wren_b, busy_b, done_b;

    rc4_encrypt #(.MSG_LEN(9), .KEY_BYTES(3)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .secret_key(key_a),
        .s_addr(s_addr_a), .s_wdata(s_wdata_a), .s_wren(s_wren_a), .s_rdata(s_rdata_a),
        .p_addr(p_addr_a), .p_rdata(p_rdata_a),
        .c_addr(c_addr_a), .c_wdata(c_wdata_a), .c_wren(c_wren_a),
        .busy(busy_a), .done_flag(done_a)
    );

    rc4_encrypt #(.MSG_LEN(256), .KEY_BYTES(3)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .secret_key(key_b),
        .s_addr(s_addr_b), .s_wdata(s_wdata_b), .s_wren(s_wren_b), .s_rdata(s_rdata_b),
        .p_addr(p_addr_b), .p_rdata(p_rdata_b),
        .c_addr(c_addr_b), .c_wdata(c_wdata_b), .c_wren(c_wren_b),
        .busy(busy_b), .done_flag(done_b)
    );

    logic [7:0] s_mem_a [256];
    logic [7:0] p_rom_a [256];
    logic [7:0] c_mem_a [256];
    logic [7:0] exp_a   [256];
    logic [7:0] s_mem_b [256];
    logic [7:0] p_rom_b [256];
    logic [7:0] c_mem_b [256];
    logic [7:0] exp_b   [256];

    // Synchronous memories: address sampled at the edge, data registered.
    always @(posedge clk) begin
        if (s_wren_a) s_mem_a[s_addr_a] <= s_wdata_a;
        s_rdata_a <= s_mem_a[s_addr_a];
        p_rdata_a <= p_rom_a[p_addr_a];
        if (c_wren_a) c_mem_a[c_addr_a] <= c_wdata_a;
        if (s_wren_b) s_mem_b[s_addr_b] <= s_wdata_b;
        s_rdata_b <= s_mem_b[s_addr_b];
        p_rdata_b <= p_rom_b[p_addr_b];
        if (c_wren_b) c_mem_b[c_addr_b] <= c_wdata_b;
    end

    int checks   = 0;
    int failures = 0;
    int wr_a     = 0;
    int wr_b     = 0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    function automatic logic [7:0] alpha(input int n);
        return 8'(8'h61 + (n % 32) % 26);
    endfunction

    // Plain RC4: KSA over a 3-byte key, then len bytes of PRGA XOR plaintext.
    task automatic rc4_model(input logic [23:0] key, input int len,
                             input logic [7:0] pt [256], output logic [7:0] ct [256]);
        int s [256];
        int i, j, t, kb;
        for (int n = 0; n < 256; n++) s[n] = n;
        j = 0;
        for (int n = 0; n < 256; n++) begin
            kb   = int'((key >> (8 * (2 - n % 3))) & 24'hFF);
            j    = (j + s[n] + kb) % 256;
            t    = s[n];
            s[n] = s[j];
            s[j] = t;
        end
        for (int n = 0; n < 256; n++) ct[n] = 8'h00;
        i = 0;
        j = 0;
        for (int n = 0; n < len; n++) begin
            i     = (i + 1) % 256;
            j     = (j + s[i]) % 256;
            t     = s[i];
            s[i]  = s[j];
            s[j]  = t;
            ct[n] = 8'(s[(s[i] + s[j]) % 256]) ^ pt[n];
        end
    endtask

    task automatic cmp_write(input string tag, input logic [7:0] addr, input logic [7:0] data,
                             input logic swren, input int wr, input int len, input logic [7:0] want);
        check({tag, "_write_in_range"}, int'(wr < len), 1);
        check({tag, "_c_addr"}, int'(addr), wr % 256);
        check({tag, "_c_wdata"}, int'(data), int'(want));
        check({tag, "_wren_exclusive"}, int'(swren), 0);
    endtask

    // Every ciphertext write is checked against the model, in order.
    always @(negedge clk) begin
        if (c_wren_a) begin
            cmp_write("a", c_addr_a, c_wdata_a, s_wren_a, wr_a, 9, exp_a[wr_a % 256]);
            wr_a++;
        end
        if (c_wren_b) begin
            cmp_write("b", c_addr_b, c_wdata_b, s_wren_b, wr_b, 256, exp_b[wr_b % 256]);
            wr_b++;
        end
    end

    task automatic check_idle_a(input string tag);
        check({tag, "_s_bus"}, int'({s_addr_a, s_wdata_a, s_wren_a}), 0);
        check({tag, "_c_bus"}, int'({c_addr_a, c_wdata_a, c_wren_a}), 0);
        check({tag, "_p_addr"}, int'(p_addr_a), 0);
        check({tag, "_busy_done"}, int'({busy_a, done_a}), 0);
    endtask

    task automatic run(input bit sel, input logic [23:0] key, input bit hold,
                       input bit init_chk, input int abort_at, output int lat);
        int    limit, wren_cnt, init_bad, busy_low;
        string tag;
        if (sel) tag = "b"; else tag = "a";
        limit    = sel ? 5000 : 2500;
        wren_cnt = 0;
        busy_low = 0;
        start_a  = 1'b0;
        start_b  = 1'b0;
        repeat (2) @(negedge clk);
        if (sel) begin key_b = key; wr_b = 0; start_b = 1'b1; end
        else     begin key_a = key; wr_a = 0; start_a = 1'b1; end
        @(negedge clk);
        // Edge E has sampled start; a later key change must not matter.
        if (sel) key_b = ~key; else key_a = ~key;
        if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
        lat = 0;
        while (!(sel ? done_b : done_a) && lat < limit) begin
            if (!(sel ? busy_b : busy_a)) busy_low++;
            if (init_chk) begin
                if (lat < 256 && s_wren_a) wren_cnt++;
                if (lat == 256) begin
                    check("init_wren_cycles", wren_cnt, 256);
                    check("init_wren_after", int'(s_wren_a), 0);
                    init_bad = 0;
                    for (int n = 0; n < 256; n++) if (s_mem_a[n] != 8'(n)) init_bad++;
                    check("init_s_contents_bad", init_bad, 0);
                end
            end
            if (lat == abort_at) begin
                reset = 1'b0;
                @(negedge clk);
                check_idle_a("midrun_reset");
                reset = 1'b1;
                lat = -1;
                return;
            end
            @(negedge clk);
            lat++;
        end
        check({tag, "_done_within_budget"}, int'(lat < limit), 1);
        check({tag, "_busy_gaps"}, busy_low, 0);
        check({tag, "_busy_at_done"}, int'(sel ? busy_b : busy_a), 0);
    endtask

    initial begin
        logic [7:0] std_ct [9];
        string      pt_str;
        int         lat, bad, stray, drop;
        std_ct = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        pt_str = "Plaintext";
        for (int n = 0; n < 256; n++) begin
            p_rom_a[n] = (n < 9) ? pt_str[n] : 8'h00;
            p_rom_b[n] = alpha(n);
        end
        reset   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        key_a   = '0;
        key_b   = '0;
        repeat (3) @(negedge clk);
        check_idle_a("reset");
        check("reset_b_busy_done", int'({busy_b, done_b}), 0);
        reset = 1'b1;

        // Standard vector, plus INIT phase inspection.
        rc4_model(24'h4B6579, 9, p_rom_a, exp_a);
        for (int n = 0; n < 9; n++) check("model_std_vector", int'(exp_a[n]), int'(std_ct[n]));
        run(1'b0, 24'h4B6579, 1'b0, 1'b1, -1, lat);
        check("a_latency", lat, 1864);
        check("a_write_count", wr_a, 9);
        for (int n = 0; n < 9; n++) check("a_std_ciphertext", int'(c_mem_a[n]), int'(std_ct[n]));

        // Reset during KSA, then a clean rerun with start held through DONE.
        run(1'b0, 24'h4B6579, 1'b0, 1'b0, 700, lat);
        check("midrun_no_writes", wr_a, 0);
        run(1'b0, 24'h4B6579, 1'b1, 1'b0, -1, lat);
        check("a_rerun_latency", lat, 1864);
        check("a_rerun_write_count", wr_a, 9);
        for (int n = 0; n < 9; n++) check("a_rerun_ciphertext", int'(c_mem_a[n]), int'(std_ct[n]));
        stray = 0;
        drop  = 0;
        repeat (100) begin
            @(negedge clk);
            if (s_wren_a || c_wren_a) stray++;
            if (!done_a) drop++;
        end
        check("hold_no_writes", stray, 0);
        check("hold_done_stays", drop, 0);
        start_a = 1'b0;
        @(negedge clk);
        check("release_done_low", int'(done_a), 0);
        check("release_busy_low", int'(busy_a), 0);

        // Round trip on the 256-byte instance.
        rc4_model(24'h000249, 256, p_rom_b, exp_b);
        run(1'b1, 24'h000249, 1'b0, 1'b0, -1, lat);
        check("b_latency", lat, 3840);
        check("b_write_count", wr_b, 256);
        for (int n = 0; n < 256; n++) p_rom_b[n] = c_mem_b[n];
        rc4_model(24'h000249, 256, p_rom_b, exp_b);
        for (int n = 0; n < 32; n++) check("model_roundtrip", int'(exp_b[n]), int'(alpha(n)));
        run(1'b1, 24'h000249, 1'b0, 1'b0, -1, lat);
        for (int n = 0; n < 32; n++) check("roundtrip_ascii", int'(c_mem_b[n]), int'(alpha(n)));
        bad = 0;
        for (int n = 0; n < 256; n++) if (c_mem_b[n] != alpha(n)) bad++;
        check("roundtrip_full_bad", bad, 0);

        // Zero key, full 256-byte message: k must terminate without wrapping.
        for (int n = 0; n < 256; n++) p_rom_b[n] = alpha(n);
        rc4_model(24'h000000, 256, p_rom_b, exp_b);
        run(1'b1, 24'h000000, 1'b0, 1'b0, -1, lat);
        check("wrap_latency", lat, 3840);
        check("wrap_write_count", wr_b, 256);
        repeat (20) @(negedge clk);
        check("wrap_no_late_writes", wr_b, 256);
        check("wrap_back_to_idle", int'({busy_b, done_b}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule
